// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch sequencer for the 64-bit core. It owns the fetch program
// counter and drives the instruction memory address. Each returned 32-bit
// word goes into a 2-entry fetch buffer together with its PC. The buffer is
// presented to decode over a valid/ready handshake.
//
// Ports:
//   clk            in   1   sole clock, rising edge
//   rst            in   1   synchronous active-high reset
//   fetch_en       in   1   allow new fetches (the buffer drains regardless)
//   imem_addr      out  64  address to instr_mem (copy of the fetch PC)
//   imem_instr     in   32  combinational read data for imem_addr
//   redirect_valid in   1   one-cycle PC change request (branch/jump)
//   redirect_pc    in   64  redirect target
//   out_valid      out  1   head of the fetch buffer is valid
//   out_ready      in   1   decode accepts the head entry this cycle
//   out_pc         out  64  PC of the head entry (0 when empty)
//   out_instr      out  32  instruction of the head entry (0 when empty)
//   misalign_err   out  1   sticky: a redirect target was not word aligned
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err
);

  localparam int DEPTH = 2;

  // Program counter and error flag
  logic [63:0] fetch_pc_reg, fetch_pc_next;
  logic        err_reg, err_next;

  // Fetch buffer storage and bookkeeping
  logic [63:0] pc_mem_reg    [DEPTH];
  logic [31:0] instr_mem_reg [DEPTH];
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic [1:0]  count_reg, count_next;

  // Registered copy of the buffer head
  logic        out_valid_reg, out_valid_next;
  logic [63:0] out_pc_reg, out_pc_next;
  logic [31:0] out_instr_reg, out_instr_next;

  logic        pop;
  logic        push;
  logic        bypass;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pop  = out_valid_reg && out_ready;
    // A full buffer can still accept a word in the same cycle the head leaves.
    push = fetch_en && !err_reg && !redirect_valid &&
           ((count_reg != 2'd2) || pop);
  end

  // ---------------------------------------------------------------------------
  // Next-state for PC, pointers, count and error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    err_next      = err_reg;

    if (redirect_valid) begin
      // The redirect flushes everything, including an entry that is being
      // handed to decode in this same cycle.
      fetch_pc_next = redirect_pc;
      rd_ptr_next   = 1'b0;
      wr_ptr_next   = 1'b0;
      count_next    = 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        err_next = 1'b1;
      end
    end else begin
      rd_ptr_next = rd_ptr_reg ^ pop;
      wr_ptr_next = wr_ptr_reg ^ push;
      count_next  = count_reg + 2'(push) - 2'(pop);
      if (push) begin
        // Natural 64-bit wrap takes ...FFFC back to 0.
        fetch_pc_next = fetch_pc_reg + 64'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next head of the buffer. When the slot that becomes the head is also being
  // written this cycle (buffer empty, or one entry popped while a new one
  // arrives), the incoming word is forwarded so the output registers see it
  // one cycle after the push.
  // ---------------------------------------------------------------------------
  always_comb begin
    bypass         = push && (wr_ptr_reg == rd_ptr_next);
    out_valid_next = (count_next != 2'd0);
    out_pc_next    = 64'd0;
    out_instr_next = 32'd0;
    if (out_valid_next) begin
      if (bypass) begin
        out_pc_next    = fetch_pc_reg;
        out_instr_next = imem_instr;
      end else begin
        out_pc_next    = pc_mem_reg[rd_ptr_next];
        out_instr_next = instr_mem_reg[rd_ptr_next];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage: one write port, entry selected by the write pointer.
  // Stored data need no reset because count gates every read.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == 1'(gi))) begin
        pc_mem_reg[gi]    <= fetch_pc_reg;
        instr_mem_reg[gi] <= imem_instr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg  <= RESET_PC;
      err_reg       <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= 64'd0;
      out_instr_reg <= 32'd0;
    end else begin
      fetch_pc_reg  <= fetch_pc_next;
      err_reg       <= err_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
    end
  end

  assign imem_addr    = fetch_pc_reg;
  assign out_valid    = out_valid_reg;
  assign out_pc       = out_pc_reg;
  assign out_instr    = out_instr_reg;
  assign misalign_err = err_reg;

endmodule
